// File: rtl/thread_fetch_sched.sv
// Round-robin scheduler granting one of four thread fetch requests to a shared FETCH unit.
// Optional BUSY timeout abort is built when FETCH_SCHED_TIMEOUT_EN is defined.
module thread_fetch_sched #(
   parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   req_i,
   input  logic [3:0]   we_i,
   input  logic [127:0] addr_i,
   input  logic [127:0] wdata_i,
   output logic [3:0]   done_o,
   output logic [3:0]   err_o,
   output logic [31:0]  rdata_o,
   output logic         busy_o,
   output logic         f_enable,
   output logic         write_mode,
   output logic [1:0]   f_thread,
   output logic [31:0]  f_addr,
   output logic [31:0]  f_data,
   input  logic         f_ack,
   input  logic [31:0]  f_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t     r_state;
   logic [1:0] r_rr_ptr;
   logic       w_gnt_vld;
   logic [1:0] w_gnt_id;

   // Descending scan so the smallest offset from the pointer wins.
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (req_i[r_rr_ptr + 2'(i)]) begin
            w_gnt_vld = 1'b1;
            w_gnt_id  = r_rr_ptr + 2'(i);
         end
      end
   end

`ifdef FETCH_SCHED_TIMEOUT_EN
   logic [7:0] r_cnt;
   logic       w_timeout;
   // r_cnt counts completed BUSY cycles, so the final cycle is at TIMEOUT_CYCLES-1.
   assign w_timeout = (r_cnt == TIMEOUT_CYCLES - 8'd1);
`else
   assign err_o = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rr_ptr   <= 2'd0;
         done_o     <= '0;
         rdata_o    <= '0;
         busy_o     <= 1'b0;
         f_enable   <= 1'b0;
         write_mode <= 1'b0;
         f_thread   <= 2'd0;
         f_addr     <= '0;
         f_data     <= '0;
`ifdef FETCH_SCHED_TIMEOUT_EN
         err_o      <= '0;
         r_cnt      <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_vld) begin
                  r_state    <= S_BUSY;
                  busy_o     <= 1'b1;
                  f_enable   <= 1'b1;
                  f_thread   <= w_gnt_id;
                  write_mode <= we_i[w_gnt_id];
                  f_addr     <= addr_i[{w_gnt_id, 5'b0} +: 32];
                  f_data     <= wdata_i[{w_gnt_id, 5'b0} +: 32];
`ifdef FETCH_SCHED_TIMEOUT_EN
                  r_cnt      <= '0;
`endif
               end
            end
            S_BUSY: begin
               if (f_ack) begin
                  r_state  <= S_DONE;
                  f_enable <= 1'b0;
                  done_o   <= 4'b0001 << f_thread;
                  rdata_o  <= f_rdata;
                  r_rr_ptr <= f_thread + 2'd1;
               end
`ifdef FETCH_SCHED_TIMEOUT_EN
               else if (w_timeout) begin
                  r_state  <= S_DONE;
                  f_enable <= 1'b0;
                  err_o    <= 4'b0001 << f_thread;
                  rdata_o  <= '0;
                  r_rr_ptr <= f_thread + 2'd1;
               end else begin
                  r_cnt    <= r_cnt + 8'd1;
               end
`endif
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy_o  <= 1'b0;
               done_o  <= '0;
`ifdef FETCH_SCHED_TIMEOUT_EN
               err_o   <= '0;
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/thread_fetch_sched.md
THREAD_FETCH_SCHED -- requirements
Module: thread_fetch_sched

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 8'd255, giving the BUSY-state cycles before abort; legal range 1..255; used only with FETCH_SCHED_TIMEOUT_EN.
REQ-002 The block SHALL have port clk, input, 1: single system clock; all state on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_i, input, 4: per-thread fetch request (bit n = thread n); level, held until done/err.
REQ-005 The block SHALL have port we_i, input, 4: per-thread write mode, qualified by req_i.
REQ-006 The block SHALL have port addr_i, input, 128: thread n address at [32n+31:32n].
REQ-007 The block SHALL have port wdata_i, input, 128: thread n write data at [32n+31:32n].
REQ-008 The block SHALL have port done_o, output, 4: one-cycle completion pulse, one-hot.
REQ-009 The block SHALL have port err_o, output, 4: one-cycle timeout pulse, one-hot.
REQ-010 The block SHALL have port rdata_o, output, 32: fetched data, valid while done_o is nonzero.
REQ-011 The block SHALL have port busy_o, output, 1: high in BUSY and DONE states.
REQ-012 The block SHALL have port f_enable, output, 1: enable to the FETCH unit.
REQ-013 The block SHALL have port write_mode, output, 1: FETCH write mode.
REQ-014 The block SHALL have port f_thread, output, 2: FETCH thread id.
REQ-015 The block SHALL have port f_addr, output, 32: FETCH address.
REQ-016 The block SHALL have port f_data, output, 32: FETCH write data.
REQ-017 The block SHALL have port f_ack, input, 1: FETCH acknowledge.
REQ-018 The block SHALL have port f_rdata, input, 32: FETCH read data.

Function
REQ-019 The block SHALL implement three states: IDLE, BUSY and DONE.
REQ-020 In IDLE with req_i!=0, the block SHALL grant the first requesting thread at or after rr_ptr, scanning in rotating order ptr, ptr+1, ... mod 4.
REQ-021 On the grant edge, the block SHALL latch thread id, we, addr and wdata, and enter BUSY.
REQ-022 In IDLE with req_i==0, the block SHALL remain in IDLE.
REQ-023 In BUSY, the block SHALL drive f_enable=1, with write_mode, f_thread, f_addr and f_data taken from the latched values and stable for the whole state.
REQ-024 In BUSY, when f_ack=1 on an edge, the block SHALL capture f_rdata into rdata_o, set rr_ptr=granted+1 mod 4, and enter DONE.
REQ-025 In DONE, the block SHALL hold f_enable=0 and done_o[granted]=1 for exactly one cycle, then return to IDLE.
REQ-026 The latency SHALL be: req sampled at edge k -> f_enable high after edge k; f_ack sampled at edge m -> done_o high after edge m. The minimum throughput SHALL be one transaction per 3 cycles.
REQ-027 The requester SHALL drop req_i[n] on the edge that samples done_o[n]/err_o[n]; the next IDLE evaluation SHALL see the updated req_i.
REQ-028 A req_i deassertion during BUSY SHALL NOT abort the transaction; done_o SHALL still pulse.
REQ-029 f_ack in IDLE or DONE SHALL be ignored.
REQ-030 Changes to we_i, addr_i or wdata_i after the grant SHALL NOT affect the active transaction.
REQ-031 Outside DONE, done_o and err_o SHALL be 0, and rdata_o SHALL hold its last value.

Reset
REQ-032 rst_n=0 SHALL, asynchronously: set state=IDLE and rr_ptr=0; drive f_enable, write_mode, f_thread, f_addr, f_data, done_o, err_o, rdata_o and busy_o to 0; and clear the timeout counter.
REQ-033 A reset during BUSY SHALL abandon the transaction with no done_o/err_o pulse; an f_ack arriving after reset release SHALL be ignored.

Configuration
REQ-034 With FETCH_SCHED_TIMEOUT_EN defined, an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without f_ack.
REQ-035 With FETCH_SCHED_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES without f_ack, the block SHALL enter DONE, pulse err_o[granted] (done_o stays 0), set rdata_o=0 and advance rr_ptr.
REQ-036 With FETCH_SCHED_TIMEOUT_EN defined, f_ack on the same edge as the timeout SHALL take precedence: normal completion.
REQ-037 Without FETCH_SCHED_TIMEOUT_EN, no counter SHALL be built, err_o SHALL be tied to 0, and BUSY SHALL wait indefinitely for f_ack.

Verification
REQ-038 Single read: req_i=4'b0100, addr_i[95:64]=32'h1000, f_ack after 2 BUSY cycles with f_rdata=32'hDEADBEEF -> f_thread=2, f_addr=32'h1000, write_mode=0, done_o=4'b0100 for one cycle, rdata_o=32'hDEADBEEF.
REQ-039 Round robin: req_i=4'b1111 held, immediate ack -> grant order 0,1,2,3,0; no thread starves.
REQ-040 Write: req_i=4'b0001, we_i=4'b0001, wdata_i[31:0]=32'h1 -> write_mode=1, f_data=32'h1, done_o=4'b0001.
REQ-041 Reset mid-BUSY: rst_n low during BUSY -> all outputs 0 immediately; f_ack after release -> no done_o.
REQ-042 Timeout (macro on, TIMEOUT_CYCLES=4): no ack -> err_o pulse after 4 BUSY cycles, rdata_o=0; ack on cycle 4 -> done_o instead of err_o.
